dev_bus_master: RTL and testbench
=================================

DEV_BUS_MASTER -- requirements
Module: dev_bus_master

Interface
REQ-001 SHALL have parameter DEV_BASE, default 32'h0000_7F00, lowest legal device address.
REQ-002 SHALL have parameter DEV_LIMIT, default 32'h0000_7F1F, highest legal device address.
REQ-003 SHALL have one clock and a synchronous, active-low reset: CLK  in  1  clock; RST  in  1  synchronous active-low reset.
REQ-004 SHALL have these request ports: Req_Valid in 1 request present; Req_Ready out 1 request accepted; Req_Write in 1 1=write/0=read; Req_Addr in 32 byte address; Req_WData in 32 write data.
REQ-005 SHALL have these response ports: Rsp_Valid out 1 response present; Rsp_Ready in 1 consumer accepts; Rsp_RData out 32 read data; Rsp_Err out 1 rejected access.
REQ-006 SHALL have these device-bus ports: CPU_Addr out 32 bridge address; CPU_WD out 32 bridge write data; DEV_WE out 1 bridge write enable; CPU_RD in 32 bridge read data (combinational); HWInt in 6 device interrupt lines.
REQ-007 SHALL have these interrupt ports: IRQ_Mask in 6 1=masked; IRQ_Ack in 6 clear pending; IRQ_Pending out 6 latched events; IRQ out 1 any unmasked pending.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-009 SHALL assert Req_Ready only in IDLE; handshake is Req_Valid&Req_Ready at a rising CLK edge.
REQ-010 SHALL, on an accepted legal request, register the request and enter ISSUE for exactly one cycle.
REQ-011 SHALL, in ISSUE, drive CPU_Addr/CPU_WD from the registered request and DEV_WE=Req_Write.
REQ-012 SHALL, outside ISSUE, drive DEV_WE=0, CPU_Addr=0, CPU_WD=0.
REQ-013 SHALL, on a read, capture CPU_RD at the end of the ISSUE cycle into Rsp_RData; on a write, Rsp_RData=0.
REQ-014 SHALL enter RESP after ISSUE; Rsp_Valid=1 in RESP, with Rsp_RData/Rsp_Err stable until Rsp_Valid&Rsp_Ready, then return to IDLE.
REQ-015 SHALL give latency: accept at edge N, bus cycle N..N+1, Rsp_Valid high from edge N+1; fastest back-to-back issue every 3 cycles.
REQ-016 SHALL treat illegal requests (misaligned Req_Addr[1:0]!=0 or outside DEV_BASE..DEV_LIMIT) as follows: no bus cycle; go IDLE->RESP directly; Rsp_Err=1; Rsp_RData=0.
REQ-017 SHALL register HWInt each cycle and set IRQ_Pending[i] on a 0->1 transition of HWInt[i].
REQ-018 SHALL clear IRQ_Pending[i] when IRQ_Ack[i]=1; simultaneous set and ack SHALL leave the bit set.
REQ-019 SHALL drive IRQ = |(IRQ_Pending & ~IRQ_Mask) combinationally.
REQ-020 SHALL keep a level-high HWInt from re-setting pending after ack until it falls and rises again.

Reset
REQ-021 SHALL, when RST=0 at a rising edge, enter IDLE and clear: Rsp_Valid, Rsp_Err, Rsp_RData, IRQ_Pending, the HWInt history register, and all bus outputs.
REQ-022 SHALL abort any in-flight ISSUE/RESP on reset mid-operation with no response delivered; DEV_WE=0 from the reset edge.
REQ-023 SHALL treat HWInt held high through reset release as already seen (no pending).

Configuration
REQ-024 SHALL compile the address check of REQ-016 only when DEV_BUS_ADDR_CHECK_EN is defined.
REQ-025 SHALL, when DEV_BUS_ADDR_CHECK_EN is undefined, issue every address, tie Rsp_Err=0, and ignore DEV_BASE/DEV_LIMIT.

Structure
REQ-026 SHALL put the FSM state encoding, default DEV_BASE/DEV_LIMIT, and timer register offsets (CTRL=0x0, PRESET=0x4, COUNT=0x8; timer0 at 0x7F00, timer1 at 0x7F10) in package dev_bus_pkg.
REQ-027 SHALL implement REQ-017..REQ-020 in sub-module irq_edge_latch (6-bit, parameterisable width).

Verification
REQ-028 SHALL verify: write 0x7F04=5 -> DEV_WE=1 for exactly one cycle with CPU_Addr=0x7F04, CPU_WD=5; Rsp_Valid next cycle, Rsp_Err=0.
REQ-029 SHALL verify: read 0x7F04 with bridge returning 5 -> Rsp_RData=5; Rsp_Ready held low 4 cycles -> Rsp_Valid/Rsp_RData stable; Req_Ready=0 throughout.
REQ-030 SHALL verify: with check enabled, read 0x7F02 or 0x8000 -> no DEV_WE, no address change, Rsp_Err=1, Rsp_RData=0.
REQ-031 SHALL verify: HWInt[2] pulses 0->1 with mask 0 -> IRQ_Pending=6'b000100, IRQ=1; IRQ_Ack[2] -> cleared; mask bit 2 set -> IRQ=0 while pending stays.
REQ-032 SHALL verify: simultaneous HWInt[0] rise and IRQ_Ack[0] -> bit stays set.
REQ-033 SHALL verify: RST=0 during ISSUE of write 0x7F00=0x9 -> DEV_WE=0 from the reset edge, state IDLE, no Rsp_Valid.

Source files
------------

// File: rtl/dev_bus_pkg.sv
// Shared definitions for the device-bus master: FSM encoding, default device window,
// timer register map and the address legality helper.
package dev_bus_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    localparam logic [31:0] DevBaseDefault  = 32'h0000_7F00;
    localparam logic [31:0] DevLimitDefault = 32'h0000_7F1F;

    // Timer register offsets within each timer block.
    localparam logic [31:0] TimerCtrlOff   = 32'h0;
    localparam logic [31:0] TimerPresetOff = 32'h4;
    localparam logic [31:0] TimerCountOff  = 32'h8;

    localparam logic [31:0] Timer0Base = 32'h0000_7F00;
    localparam logic [31:0] Timer1Base = 32'h0000_7F10;

    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] limit);
        return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge interrupt latch: pending bits set on a 0->1 input edge, cleared by ack,
// with set winning over a simultaneous ack. IRQ is the OR of unmasked pending bits.
module irq_edge_latch #(
    parameter int unsigned Width = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] hw_int,
    input  logic [Width-1:0] mask,
    input  logic [Width-1:0] ack,
    output logic [Width-1:0] pending,
    output logic             irq
);

    logic [Width-1:0] hist_q;
    logic             armed_q;
    logic [Width-1:0] rise;

    // First cycle after reset only samples history, so lines held high through reset are
    // treated as already seen.
    assign rise = hw_int & ~hist_q & {Width{armed_q}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q  <= '0;
            armed_q <= 1'b0;
            pending <= '0;
        end else begin
            hist_q  <= hw_int;
            armed_q <= 1'b1;
            pending <= (pending & ~ack) | rise;
        end
    end

    assign irq = |(pending & ~mask);

endmodule

// File: rtl/dev_bus_master.sv
// Request/response front end driving a single-cycle device bridge, plus an interrupt latch.
// Optional address window / alignment check enabled by defining DEV_BUS_ADDR_CHECK_EN.
module dev_bus_master
    import dev_bus_pkg::*;
#(
    parameter logic [31:0] DEV_BASE  = DevBaseDefault,
    parameter logic [31:0] DEV_LIMIT = DevLimitDefault
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_WData,

    output logic        Rsp_Valid,
    input  logic        Rsp_Ready,
    output logic [31:0] Rsp_RData,
    output logic        Rsp_Err,

    output logic [31:0] CPU_Addr,
    output logic [31:0] CPU_WD,
    output logic        DEV_WE,
    input  logic [31:0] CPU_RD,
    input  logic [5:0]  HWInt,

    input  logic [5:0]  IRQ_Mask,
    input  logic [5:0]  IRQ_Ack,
    output logic [5:0]  IRQ_Pending,
    output logic        IRQ
);

    state_e state_q;
    logic   wr_q;
    logic   rsp_err_q;
    logic   req_legal;

`ifdef DEV_BUS_ADDR_CHECK_EN
    assign req_legal = addr_legal(Req_Addr, DEV_BASE, DEV_LIMIT);
    assign Rsp_Err   = rsp_err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{DEV_BASE, DEV_LIMIT, rsp_err_q};
    assign req_legal  = 1'b1;
    assign Rsp_Err    = 1'b0;
`endif

    assign Req_Ready = (state_q == StIdle);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= StIdle;
            wr_q      <= 1'b0;
            rsp_err_q <= 1'b0;
            Rsp_Valid <= 1'b0;
            Rsp_RData <= '0;
            CPU_Addr  <= '0;
            CPU_WD    <= '0;
            DEV_WE    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Req_Valid) begin
                        if (req_legal) begin
                            state_q  <= StIssue;
                            wr_q     <= Req_Write;
                            CPU_Addr <= Req_Addr;
                            CPU_WD   <= Req_WData;
                            DEV_WE   <= Req_Write;
                        end else begin
                            // Rejected access skips the bus cycle entirely.
                            state_q   <= StResp;
                            rsp_err_q <= 1'b1;
                            Rsp_RData <= '0;
                            Rsp_Valid <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    state_q   <= StResp;
                    CPU_Addr  <= '0;
                    CPU_WD    <= '0;
                    DEV_WE    <= 1'b0;
                    rsp_err_q <= 1'b0;
                    Rsp_RData <= wr_q ? 32'h0 : CPU_RD;
                    Rsp_Valid <= 1'b1;
                end
                StResp: begin
                    if (Rsp_Ready) begin
                        state_q   <= StIdle;
                        Rsp_Valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    irq_edge_latch #(
        .Width(6)
    ) u_irq (
        .clk    (CLK),
        .rst_n  (RST),
        .hw_int (HWInt),
        .mask   (IRQ_Mask),
        .ack    (IRQ_Ack),
        .pending(IRQ_Pending),
        .irq    (IRQ)
    );

endmodule

// File: tb/tb_dev_bus_master.sv
// Self-checking bench for dev_bus_master: table vectors, hand sequences and random
// stimulus against a behavioural model of the bus and interrupt rules.
module tb_dev_bus_master;

`ifdef DEV_BUS_ADDR_CHECK_EN
    localparam bit Chk = 1'b1;
`else
    localparam bit Chk = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        Req_Valid, Req_Ready, Req_Write;
    logic [31:0] Req_Addr, Req_WData;
    logic        Rsp_Valid, Rsp_Ready, Rsp_Err;
    logic [31:0] Rsp_RData;
    logic [31:0] CPU_Addr, CPU_WD, CPU_RD;
    logic        DEV_WE;
    logic [5:0]  HWInt, IRQ_Mask, IRQ_Ack, IRQ_Pending;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dev_bus_master dut (
        .CLK        (CLK),
        .RST        (RST),
        .Req_Valid  (Req_Valid),
        .Req_Ready  (Req_Ready),
        .Req_Write  (Req_Write),
        .Req_Addr   (Req_Addr),
        .Req_WData  (Req_WData),
        .Rsp_Valid  (Rsp_Valid),
        .Rsp_Ready  (Rsp_Ready),
        .Rsp_RData  (Rsp_RData),
        .Rsp_Err    (Rsp_Err),
        .CPU_Addr   (CPU_Addr),
        .CPU_WD     (CPU_WD),
        .DEV_WE     (DEV_WE),
        .CPU_RD     (CPU_RD),
        .HWInt      (HWInt),
        .IRQ_Mask   (IRQ_Mask),
        .IRQ_Ack    (IRQ_Ack),
        .IRQ_Pending(IRQ_Pending),
        .IRQ        (IRQ)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_illegal(input logic [31:0] addr);
        return Chk && ((addr[1:0] != 2'b00) || (addr < 32'h7F00) || (addr > 32'h7F1F));
    endfunction

    // One full request/response; every check happens on a falling edge.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int hold,
                          input logic exp_err, input logic [31:0] exp_rdata);
        @(negedge CLK);
        chk("req_ready_idle", 32'(Req_Ready), 32'd1);
        Req_Valid = 1'b1;
        Req_Write = wr;
        Req_Addr  = addr;
        Req_WData = wd;
        CPU_RD    = ~rd;
        @(negedge CLK);
        Req_Valid = 1'b0;
        chk("req_ready_busy", 32'(Req_Ready), 32'd0);
        if (!exp_err) begin
            chk("issue_dev_we", 32'(DEV_WE), 32'(wr));
            chk("issue_cpu_addr", CPU_Addr, addr);
            chk("issue_cpu_wd", CPU_WD, wd);
            chk("issue_rsp_valid", 32'(Rsp_Valid), 32'd0);
            CPU_RD = rd;
            @(negedge CLK);
        end
        chk("resp_dev_we", 32'(DEV_WE), 32'd0);
        chk("resp_cpu_addr", CPU_Addr, 32'd0);
        chk("resp_cpu_wd", CPU_WD, 32'd0);
        chk("resp_valid", 32'(Rsp_Valid), 32'd1);
        chk("resp_rdata", Rsp_RData, exp_rdata);
        chk("resp_err", 32'(Rsp_Err), 32'(exp_err));
        CPU_RD = 32'hFFFF_FFFF;
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            chk("hold_valid", 32'(Rsp_Valid), 32'd1);
            chk("hold_rdata", Rsp_RData, exp_rdata);
            chk("hold_err", 32'(Rsp_Err), 32'(exp_err));
            chk("hold_req_ready", 32'(Req_Ready), 32'd0);
            chk("hold_dev_we", 32'(DEV_WE), 32'd0);
        end
        Rsp_Ready = 1'b1;
        @(negedge CLK);
        Rsp_Ready = 1'b0;
        chk("after_rsp_valid", 32'(Rsp_Valid), 32'd0);
        chk("after_req_ready", 32'(Req_Ready), 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        tbl[8];
    logic [5:0]  m_pend, m_prev, r_hw, r_ack, r_mask;
    logic        r_wr, e_err;
    logic [31:0] r_addr, r_wd, r_rd, e_rd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h7F04, 32'h5,         32'h0,         0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h7F04, 32'h0,         32'h5,         4, 1'b0, 32'h5};
        tbl[2] = '{1'b0, 32'h7F02, 32'h0,         32'hAA,        1, Chk,  Chk ? 32'h0 : 32'hAA};
        tbl[3] = '{1'b0, 32'h8000, 32'h0,         32'h1234,      0, Chk,  Chk ? 32'h0 : 32'h1234};
        tbl[4] = '{1'b1, 32'h7F1C, 32'hDEADBEEF,  32'h55,        0, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 32'h7F10, 32'h0,         32'hCAFEF00D,  2, 1'b0, 32'hCAFEF00D};
        tbl[6] = '{1'b1, 32'h7EFC, 32'h1,         32'h0,         0, Chk,  32'h0};
        tbl[7] = '{1'b0, 32'h7F20, 32'h0,         32'h77,        0, Chk,  Chk ? 32'h0 : 32'h77};

        RST = 1'b0;
        Req_Valid = 1'b0; Req_Write = 1'b0; Req_Addr = '0; Req_WData = '0;
        Rsp_Ready = 1'b0; CPU_RD = '0;
        HWInt = 6'b100000; IRQ_Mask = '0; IRQ_Ack = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", 32'(Req_Ready), 32'd1);
        chk("rst_rsp_valid", 32'(Rsp_Valid), 32'd0);
        chk("rst_rsp_err", 32'(Rsp_Err), 32'd0);
        chk("rst_rsp_rdata", Rsp_RData, 32'd0);
        chk("rst_dev_we", 32'(DEV_WE), 32'd0);
        chk("rst_cpu_addr", CPU_Addr, 32'd0);
        chk("rst_cpu_wd", CPU_WD, 32'd0);
        chk("rst_pending", 32'(IRQ_Pending), 32'd0);
        RST = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk("held_high_no_pending", 32'(IRQ_Pending), 32'd0);
            chk("held_high_no_irq", 32'(IRQ), 32'd0);
        end

        // Interrupt hand sequences; HWInt[5] stays high throughout.
        HWInt = 6'b100100;
        @(negedge CLK);
        HWInt = 6'b100000;
        chk("irq2_pending", 32'(IRQ_Pending), 32'b000100);
        chk("irq2_irq", 32'(IRQ), 32'd1);
        IRQ_Ack = 6'b000100;
        @(negedge CLK);
        IRQ_Ack = '0;
        chk("irq2_acked", 32'(IRQ_Pending), 32'd0);
        chk("irq2_acked_irq", 32'(IRQ), 32'd0);
        HWInt = 6'b100100;
        @(negedge CLK);
        HWInt = 6'b100000;
        IRQ_Mask = 6'b000100;
        #1;
        chk("irq2_masked_irq", 32'(IRQ), 32'd0);
        chk("irq2_masked_pending", 32'(IRQ_Pending), 32'b000100);
        IRQ_Ack = 6'b000100;
        @(negedge CLK);
        IRQ_Ack = '0;
        IRQ_Mask = '0;
        HWInt = 6'b100001;
        IRQ_Ack = 6'b000001;
        @(negedge CLK);
        IRQ_Ack = '0;
        chk("set_beats_ack", 32'(IRQ_Pending), 32'b000001);
        IRQ_Ack = 6'b000001;
        @(negedge CLK);
        IRQ_Ack = '0;
        chk("level_ack_clears", 32'(IRQ_Pending), 32'd0);
        @(negedge CLK);
        chk("level_no_reset", 32'(IRQ_Pending), 32'd0);
        HWInt = 6'b100000;
        @(negedge CLK);
        HWInt = 6'b100001;
        @(negedge CLK);
        chk("level_re_rise", 32'(IRQ_Pending), 32'b000001);
        IRQ_Ack = 6'b111111;
        @(negedge CLK);
        IRQ_Ack = '0;

        for (int i = 0; i < 8; i++)
            do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].hold,
                   tbl[i].exp_err, tbl[i].exp_rdata);

        // Reset during the ISSUE cycle of a write aborts it.
        @(negedge CLK);
        Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = 32'h7F00; Req_WData = 32'h9;
        @(negedge CLK);
        Req_Valid = 1'b0;
        chk("abort_issue_we", 32'(DEV_WE), 32'd1);
        RST = 1'b0;
        @(negedge CLK);
        chk("abort_dev_we", 32'(DEV_WE), 32'd0);
        chk("abort_cpu_addr", CPU_Addr, 32'd0);
        chk("abort_idle", 32'(Req_Ready), 32'd1);
        chk("abort_no_rsp", 32'(Rsp_Valid), 32'd0);
        RST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("abort_still_no_rsp", 32'(Rsp_Valid), 32'd0);
            chk("abort_pending_clear", 32'(IRQ_Pending), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            r_wr = 1'($urandom);
            r_wd = $urandom;
            r_rd = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    r_addr = 32'h7F00 + 32'(4 * $urandom_range(0, 7));
                2:       r_addr = 32'h7F00 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
                default: r_addr = $urandom_range(0, 1) ? 32'h8000 + 32'(4 * $urandom_range(0, 255))
                                                       : 32'h7E00 + 32'(4 * $urandom_range(0, 63));
            endcase
            e_err = model_illegal(r_addr);
            e_rd  = (e_err || r_wr) ? 32'h0 : r_rd;
            do_txn(r_wr, r_addr, r_wd, r_rd, $urandom_range(0, 3), e_err, e_rd);
        end

        m_pend = '0;
        m_prev = HWInt;
        for (int c = 0; c < 60; c++) begin
            r_hw   = 6'($urandom);
            r_ack  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            r_mask = 6'($urandom);
            HWInt = r_hw; IRQ_Ack = r_ack; IRQ_Mask = r_mask;
            @(posedge CLK);
            m_pend = (m_pend & ~r_ack) | (r_hw & ~m_prev);
            m_prev = r_hw;
            @(negedge CLK);
            chk("rand_pending", 32'(IRQ_Pending), 32'(m_pend));
            chk("rand_irq", 32'(IRQ), 32'(|(m_pend & ~r_mask)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
